// File: rtl/alu_pkg.sv
// Shared types for the alu slice and the multi-precision sequencer that drives it.
package alu_pkg;

  typedef enum logic [3:0] {
    PASSTHROUGH  = 4'd0,
    ADD_WITH_CIN = 4'd1,
    SUB_WITH_CIN = 4'd2,
    BIT_AND      = 4'd3,
    BIT_OR       = 4'd4,
    BIT_XOR      = 4'd5,
    BIT_NOT      = 4'd6
  } opcode;

  typedef enum logic [2:0] {
    MP_ADD = 3'd0,
    MP_ADC = 3'd1,
    MP_SUB = 3'd2,
    MP_SBB = 3'd3,
    MP_AND = 3'd4,
    MP_OR  = 3'd5,
    MP_XOR = 3'd6,
    MP_NOT = 3'd7
  } mp_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  function automatic logic mp_is_arith(mp_op_t op);
    return (op == MP_ADD) || (op == MP_ADC) || (op == MP_SUB) || (op == MP_SBB);
  endfunction

  function automatic logic mp_is_sub(mp_op_t op);
    return (op == MP_SUB) || (op == MP_SBB);
  endfunction

  function automatic opcode mp_slice_op(mp_op_t op);
    case (op)
      MP_ADD, MP_ADC: return ADD_WITH_CIN;
      MP_SUB, MP_SBB: return SUB_WITH_CIN;
      MP_AND:         return BIT_AND;
      MP_OR:          return BIT_OR;
      MP_XOR:         return BIT_XOR;
      default:        return BIT_NOT;
    endcase
  endfunction

  // Subtract carries "no borrow", so a plain SUB starts with carry set.
  function automatic logic mp_init_carry(mp_op_t op, logic c_in);
    case (op)
      MP_SUB:         return 1'b1;
      MP_ADC, MP_SBB: return c_in;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mp_sequencer.sv
// Walks a WIDTH*WORDS-bit request through a WIDTH-bit alu slice, LSW first,
// chaining carry and assembling the wide result plus flags.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | one slice per cycle, idx selects the word
// DONE  | response held on rsp_* until rsp_ready
module alu_mp_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  mp_op_t                 req_op,
  input  logic [WIDTH*WORDS-1:0] req_a,
  input  logic [WIDTH*WORDS-1:0] req_b,
  input  logic                   req_c_in,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH*WORDS-1:0] rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   rsp_negative,
  output logic                   rsp_overflow,
  output logic [WIDTH-1:0]       alu_A,
  output logic [WIDTH-1:0]       alu_B,
  output logic                   alu_c_in,
  output opcode                  alu_op,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_c_out
);

  localparam int TOT   = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  mp_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  mp_op_t           op_q;
  logic [TOT-1:0]   a_q, b_q, result_q;
  logic             carry_q, zacc_q;
  logic             last;

  assign last = (idx_q == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    alu_op    = PASSTHROUGH;
    alu_A     = '0;
    alu_B     = '0;
    alu_c_in  = 1'b0;
    if (state_q == RUN) begin
      alu_op   = mp_slice_op(op_q);
      alu_A    = a_q[int'(idx_q)*WIDTH +: WIDTH];
      alu_B    = b_q[int'(idx_q)*WIDTH +: WIDTH];
      alu_c_in = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      op_q     <= MP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          a_q     <= req_a;
          b_q     <= req_b;
          carry_q <= mp_init_carry(req_op, req_c_in);
          idx_q   <= '0;
          zacc_q  <= 1'b1;
        end
        RUN: begin
          result_q[int'(idx_q)*WIDTH +: WIDTH] <= alu_out;
          carry_q <= mp_is_arith(op_q) ? alu_c_out : 1'b0;
          zacc_q  <= zacc_q && (alu_out == '0);
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Overflow is derived from the top word here rather than from slice flags.
  always_comb begin
    rsp_overflow = 1'b0;
    if (mp_is_arith(op_q)) begin
      if (mp_is_sub(op_q))
        rsp_overflow = (a_q[TOT-1] != b_q[TOT-1]) && (result_q[TOT-1] != a_q[TOT-1]);
      else
        rsp_overflow = (a_q[TOT-1] == b_q[TOT-1]) && (result_q[TOT-1] != a_q[TOT-1]);
    end
  end

  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_zero     = zacc_q;
  assign rsp_negative = result_q[TOT-1];

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Directed bench for alu_mp_sequencer with a behavioral unsigned-carry alu slice.
module tb_alu_mp_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int TOT   = WIDTH * WORDS;

  logic           clk, rst;
  logic           req_valid, req_ready, req_c_in;
  mp_op_t         req_op;
  logic [TOT-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [TOT-1:0] rsp_result;
  logic           rsp_carry, rsp_zero, rsp_negative, rsp_overflow;
  logic [WIDTH-1:0] alu_A, alu_B, alu_out;
  logic           alu_c_in, alu_c_out;
  opcode          alu_op;
  logic [WIDTH:0] s;

  int n_pass = 0;
  int n_total = 0;

  alu_mp_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .rsp_overflow(rsp_overflow),
    .alu_A(alu_A), .alu_B(alu_B), .alu_c_in(alu_c_in), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c_out(alu_c_out)
  );

  always_comb begin
    s         = '0;
    alu_out   = alu_A;
    alu_c_out = 1'b0;
    case (alu_op)
      ADD_WITH_CIN: begin
        s = {1'b0, alu_A} + {1'b0, alu_B} + 9'(alu_c_in);
        alu_out = s[WIDTH-1:0]; alu_c_out = s[WIDTH];
      end
      SUB_WITH_CIN: begin
        s = {1'b0, alu_A} + {1'b0, ~alu_B} + 9'(alu_c_in);
        alu_out = s[WIDTH-1:0]; alu_c_out = s[WIDTH];
      end
      BIT_AND: alu_out = alu_A & alu_B;
      BIT_OR:  alu_out = alu_A | alu_B;
      BIT_XOR: alu_out = alu_A ^ alu_B;
      BIT_NOT: alu_out = ~alu_A;
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Entered one step after a rising edge with the DUT idle.
  task automatic issue(input mp_op_t op, input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                       input logic cin);
    req_op = op; req_a = a; req_b = b; req_c_in = cin; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = mp_op_t'($urandom_range(0, 7));
    req_a = $urandom; req_b = $urandom; req_c_in = ~cin;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_rsp(input string tag, input logic [TOT-1:0] r, input logic c,
                           input logic z, input logic n, input logic v);
    chk({tag, "_result"}, rsp_result, r);
    chk({tag, "_carry"}, rsp_carry, c);
    chk({tag, "_zero"}, rsp_zero, z);
    chk({tag, "_neg"}, rsp_negative, n);
    chk({tag, "_ovf"}, rsp_overflow, v);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input mp_op_t op, input logic [TOT-1:0] a,
                        input logic [TOT-1:0] b, input logic cin, input logic [TOT-1:0] r,
                        input logic c, input logic z, input logic n, input logic v);
    int cyc;
    issue(op, a, b, cin);
    chk({tag, "_slice_op"}, alu_op, mp_slice_op(op));
    chk({tag, "_slice_a0"}, alu_A, a[WIDTH-1:0]);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, WORDS);
    check_rsp(tag, r, c, z, n, v);
    handshake();
  endtask

  initial begin
    int cyc;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = MP_ADD;
    req_a = '0; req_b = '0; req_c_in = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_op", alu_op, PASSTHROUGH);
    chk("rst_alu_a", alu_A, 8'h00);
    check_rsp("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("add_ff_1",   MP_ADD, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 0, 0, 0, 0);
    run_op("add_wrap",   MP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1, 1, 0, 0);
    run_op("sub_ovf",    MP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1, 0, 0, 1);
    run_op("sub_borrow", MP_SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 0, 0, 1, 0);
    run_op("sbb_c0",     MP_SBB, 32'h00000005, 32'h00000005, 1'b0, 32'hFFFFFFFF, 0, 0, 1, 0);
    run_op("xor_self",   MP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 0, 1, 0, 0);
    run_op("adc_c1",     MP_ADC, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 0, 0, 0, 0);
    run_op("add_povf",   MP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 0, 0, 1, 1);
    run_op("not_a",      MP_NOT, 32'h0F0F0000, 32'h12345678, 1'b1, 32'hF0F0FFFF, 0, 0, 1, 0);
    run_op("or_ab",      MP_OR,  32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 0, 0, 1, 0);
    run_op("and_ab",     MP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'h00F000F0, 0, 0, 0, 0);

    // Backpressure: hold a new request while the response is stalled.
    issue(MP_ADD, 32'h00000010, 32'h00000020, 1'b0);
    wait_done(cyc);
    chk("bp_latency", cyc, WORDS);
    req_op = MP_SUB; req_a = 32'h00000100; req_b = 32'h00000001; req_c_in = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_result", rsp_result, 32'h00000030);
      chk("bp_hold_zero", rsp_zero, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", rsp_valid, 1'b0);
    chk("bp_ready_after_f", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accepted", req_ready, 1'b0);
    chk("bp_slice_op", alu_op, SUB_WITH_CIN);
    wait_done(cyc);
    chk("bp2_latency", cyc, WORDS);
    check_rsp("bp2", 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake();

    // Asynchronous reset in the middle of RUN at idx=2.
    issue(MP_ADD, 32'h01010101, 32'h01010101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_alu_a_w2", alu_A, 8'h01);
    chk("mid_partial", rsp_result, 32'h00000202);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_alu_op", alu_op, PASSTHROUGH);
    chk("arst_alu_a", alu_A, 8'h00);
    chk("arst_alu_cin", alu_c_in, 1'b0);
    check_rsp("arst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst", MP_ADD, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mp_sequencer.md
# alu_mp_sequencer

Multi-precision arithmetic/logic sequencer that issues a WORDS-long series of slice operations to a WIDTH-bit `alu` instance and assembles a WIDTH*WORDS-bit result with flags. It accepts one wide request over a valid/ready handshake and walks the operand words LSW-first, chaining carry through the slice. It returns the result over a valid/ready response channel. It sits beside `alu` in the datapath top (`alu_mp_top`), on the driving side of the `alu` port set.

## Interface
- `WIDTH`, 8, slice width; must match the attached `alu`
- `WORDS`, 4, number of slices per request; ≥2
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a clock edge
- `req_op`  in  `mp_op_t` (3)  operation
- `req_a`, `req_b`  in  WIDTH*WORDS  operands
- `req_c_in`  in  1  carry/no-borrow in; used by MP_ADC/MP_SBB only
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready` at a clock edge
- `rsp_result`  out  WIDTH*WORDS  result
- `rsp_carry`, `rsp_zero`, `rsp_negative`, `rsp_overflow`  out  1 each  result flags
- `alu_A`, `alu_B`  out  WIDTH  slice operands
- `alu_c_in`  out  1  slice carry in
- `alu_op`  out  `opcode` (4)  slice opcode
- `alu_out`  in  WIDTH  slice result; combinational response to `alu_*` in the same cycle
- `alu_c_out`  in  1  slice carry out; must be the unsigned carry, i.e. bit WIDTH of the zero-extended sum

## Operation
- `mp_op_t` encodings: MP_ADD=0, MP_ADC=1, MP_SUB=2, MP_SBB=3, MP_AND=4, MP_OR=5, MP_XOR=6, MP_NOT=7. All codes are legal.
- Slice opcode mapping:
  - ADD/ADC → ADD_WITH_CIN
  - SUB/SBB → SUB_WITH_CIN (A + ~B + c_in; c_in=1 means no borrow)
  - AND/OR/XOR/NOT → BIT_AND/BIT_OR/BIT_XOR/BIT_NOT
- Initial carry: ADD=0, SUB=1, ADC/SBB=`req_c_in`, bitwise=0.
- FSM states:
  - IDLE: `req_ready`=1. On handshake, capture op, a, b and initial carry; `idx`←0; `zacc`←1; go to RUN.
  - RUN: drive `alu_A`=a[idx], `alu_B`=b[idx], `alu_c_in`=carry, `alu_op`=mapped. Each edge: result[idx]←`alu_out`; carry←`alu_c_out` for arithmetic ops, 0 for bitwise; `zacc`←`zacc && alu_out==0`. When idx=WORDS-1, go to DONE; otherwise idx+1.
  - DONE: `rsp_valid`=1 and all `rsp_*` held stable. On handshake, go to IDLE.
- Word k occupies bits [k*WIDTH +: WIDTH].
- Flags:
  - `rsp_carry` = final carry
  - `rsp_zero` = `zacc`
  - `rsp_negative` = result MSB
  - `rsp_overflow` is computed locally on the top word, never taken from `alu` flags: ADD/ADC: (a_msb==b_msb)&&(r_msb!=a_msb); SUB/SBB: (a_msb!=b_msb)&&(r_msb!=a_msb); bitwise: 0.
- Outside RUN: `alu_op`=PASSTHROUGH, `alu_A`=`alu_B`=0, `alu_c_in`=0.
- `idx` never wraps past WORDS-1. `req_ready` is 0 in RUN and DONE; requests are not queued.

## Timing
- Reset values:
  - FSM in IDLE, `req_ready`=1, `rsp_valid`=0
  - `rsp_result`=0; all `rsp_*` flags 0
  - `alu_*` outputs at their idle values
- Reset asserted mid-RUN or in DONE: the operation is discarded immediately, and the above values are reached without waiting for a clock edge.
- Latency: request accepted at edge E; RUN occupies edges E+1..E+WORDS; `rsp_valid`=1 after edge E+WORDS.
- Throughput: after the response handshake at edge F, `req_ready`=1 after F. Next accept is at F+1 at the earliest, giving one request per WORDS+2 cycles.
- `rsp_ready` may be held high in advance; the handshake then completes on the first DONE edge.
- `req_*` inputs are sampled only at the accept edge; later changes have no effect.

## Structure
- Shared package `alu_pkg` holds:
  - the `opcode` typedef (moved out of `alu`)
  - `mp_op_t`
  - the FSM state typedef (IDLE/RUN/DONE)
- No sub-module. The `alu` instance lives in `alu_mp_top`, which wires `alu_*` ports to it. The bench uses `alu_mp_top` or a behavioral slice with unsigned-carry semantics.
- `idx` width is $clog2(WORDS).

## Test plan
All scenarios use WIDTH=8, WORDS=4.
1. MP_ADD 0x000000FF + 0x00000001 → 0x00000100; carry=0, zero=0, overflow=0; `rsp_valid` rises exactly 4 edges after accept.
2. MP_ADD 0xFFFFFFFF + 0x00000001 → 0x00000000; carry=1, zero=1, negative=0, overflow=0.
3. MP_SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF; carry=1, overflow=1, negative=0. Also 0x00000000 − 0x00000001 → 0xFFFFFFFF, carry=0.
4. MP_SBB `req_c_in`=0, 5 − 5 → 0xFFFFFFFF, carry=0, negative=1. MP_XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 → 0, zero=1, carry=0.
5. Backpressure: `rsp_ready`=0 for 3 cycles with `req_valid` held high. `rsp_*` stay stable and `req_ready`=0; after the handshake, the next request is accepted one cycle later and completes correctly.
6. Assert `rst` mid-RUN at idx=2. Outputs reach reset values before the next edge; a following MP_ADD 1+1 → 0x00000002.
